// File: rtl/galois_pkg.sv
// Shared field constants, FSM state type and exponent helpers for the
// Galois-field power block and its Barrett multiplier.
package galois_pkg;

  localparam int BN254_BITS = 254;

  // BN254 scalar-field prime. The two spare top bits of the literal are zero.
  localparam logic [255:0] BN254_P_FULL =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [BN254_BITS-1:0] BN254_P = BN254_P_FULL[BN254_BITS-1:0];

  // floor(4^k / p) with k = BN254_BITS, evaluated once at elaboration.
  function automatic logic [BN254_BITS:0] barrett_mu(input logic [BN254_BITS-1:0] p);
    logic [2*BN254_BITS:0] num;
    logic [2*BN254_BITS:0] quo;
    num = '0;
    num[2*BN254_BITS] = 1'b1;
    quo = num / {{(BN254_BITS+1){1'b0}}, p};
    return quo[BN254_BITS:0];
  endfunction

  localparam logic [BN254_BITS:0] BN254_BARRETT = barrett_mu(BN254_P);

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    MULT,
    DONE
  } pow_state_t;

  localparam int POW_EXP_W = 256;

  // Multiplier passes needed for MSB-first square-and-multiply: msb(E) + popcount(E) - 1.
  function automatic int pow_op_count(input logic [POW_EXP_W-1:0] e);
    int msb;
    int pop;
    msb = 0;
    pop = 0;
    for (int i = 0; i < POW_EXP_W; i++) begin
      if (e[i]) begin
        msb = i;
        pop = pop + 1;
      end
    end
    return (pop == 0) ? 0 : msb + pop - 1;
  endfunction

endpackage

// File: rtl/galois_mult_barrett_sync.sv
// Pipelined modular multiplier: full product, Barrett quotient estimate,
// residue correction, then a delay tail so the product appears MULT_LATENCY cycles on.
module galois_mult_barrett_sync
  import galois_pkg::*;
#(
  parameter int                 N_BITS        = BN254_BITS,
  parameter logic [N_BITS-1:0]  PRIME_MODULUS = BN254_P,
  parameter logic [N_BITS:0]    BARRETT_R     = BN254_BARRETT,
  parameter int                 MULT_LATENCY  = 12
) (
  input  logic              clk,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] product
);

  localparam int W    = N_BITS;
  localparam int TAIL = MULT_LATENCY - 2;

  logic [2*W-1:0] x_full;
  logic [2*W-1:0] x_q;
  logic [W:0]     q1;
  logic [W:0]     q3;
  logic [W:0]     q3_q;
  logic [W+1:0]   x_lo_q;
  logic [W+1:0]   qp_lo;
  logic [W+1:0]   p_ext;
  logic [W+1:0]   r0;
  logic [W+1:0]   r1;
  logic [W-1:0]   tail [TAIL];

  assign x_full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign q1     = x_q[2*W-1:W-1];
  assign q3     = (W+1)'(({{(W+1){1'b0}}, q1} * {{(W+1){1'b0}}, BARRETT_R}) >> (W+1));
  // Residue is below 3p, so two bits of headroom over p keep it exact.
  assign qp_lo  = (W+2)'({{W{1'b0}}, q3_q} * {{(W+1){1'b0}}, PRIME_MODULUS});
  assign p_ext  = {2'b00, PRIME_MODULUS};
  assign r0     = x_lo_q - qp_lo;
  assign r1     = (r0 >= p_ext) ? r0 - p_ext : r0;

  // NOTE: datapath pipeline registers carry no reset; the controller never
  // samples the output until fresh operands have flushed the whole pipe.
  always_ff @(posedge clk) begin
    x_q     <= x_full;
    q3_q    <= q3;
    x_lo_q  <= x_q[W+1:0];
    tail[0] <= W'((r1 >= p_ext) ? r1 - p_ext : r1);
    for (int i = 1; i < TAIL; i++) begin
      tail[i] <= tail[i-1];
    end
  end

  assign product = tail[TAIL-1];

endmodule

// File: rtl/galois_pow_const.sv
// base^E mod p by MSB-first square-and-multiply over one shared Barrett multiplier;
// E is EXP or EXP_INV, chosen per job by inv.
module galois_pow_const
  import galois_pkg::*;
#(
  parameter int                  N_BITS        = BN254_BITS,
  parameter logic [N_BITS-1:0]   PRIME_MODULUS = BN254_P,
  parameter logic [N_BITS:0]     BARRETT_R     = BN254_BARRETT,
  parameter int                  EXP_BITS      = 256,
  parameter logic [EXP_BITS-1:0] EXP           = EXP_BITS'(5),
  parameter logic [EXP_BITS-1:0] EXP_INV       = EXP_BITS'(1),
  parameter int                  MULT_LATENCY  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] base,
  input  logic              inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] result
);

  localparam int PHASE_W = $clog2(MULT_LATENCY + 1);
  localparam int IDX_W   = $clog2(EXP_BITS);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(MULT_LATENCY);

  if (EXP == '0) begin : g_exp_zero
    $error("galois_pow_const: EXP must be >= 1");
  end
  if (EXP_INV == '0) begin : g_exp_inv_zero
    $error("galois_pow_const: EXP_INV must be >= 1");
  end
  if (MULT_LATENCY < 3) begin : g_lat_small
    $error("galois_pow_const: MULT_LATENCY must be >= 3");
  end

  function automatic logic [IDX_W-1:0] msb_of(input logic [EXP_BITS-1:0] e);
    logic [IDX_W-1:0] m;
    m = '0;
    for (int i = 0; i < EXP_BITS; i++) begin
      if (e[i]) m = IDX_W'(i);
    end
    return m;
  endfunction

  pow_state_t          state;
  logic [N_BITS-1:0]   base_q;
  logic [N_BITS-1:0]   acc;
  logic [N_BITS-1:0]   op_b;
  logic [N_BITS-1:0]   product;
  logic [EXP_BITS-1:0] exp_q;
  logic [EXP_BITS-1:0] exp_sel;
  logic [IDX_W-1:0]    start_msb;
  logic [IDX_W-1:0]    idx;
  logic [PHASE_W-1:0]  phase;

  assign exp_sel   = inv ? EXP_INV : EXP;
  assign start_msb = msb_of(exp_sel);

  // acc doubles as the first operand register; op_b is acc (square) or base (multiply).
  galois_mult_barrett_sync #(
    .N_BITS        (N_BITS),
    .PRIME_MODULUS (PRIME_MODULUS),
    .BARRETT_R     (BARRETT_R),
    .MULT_LATENCY  (MULT_LATENCY)
  ) u_mult (
    .clk     (clk),
    .a       (acc),
    .b       (op_b),
    .product (product)
  );

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of acc, idx and phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      base_q    <= '0;
      acc       <= '0;
      op_b      <= '0;
      exp_q     <= '0;
      idx       <= '0;
      phase     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            base_q   <= base;
            exp_q    <= exp_sel;
            acc      <= base;
            op_b     <= base;
            phase    <= '0;
            in_ready <= 1'b0;
            if (start_msb == '0) begin
              result    <= base;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              idx   <= start_msb - 1'b1;
              state <= SQUARE;
            end
          end
        end
        SQUARE: begin
          if (phase == PHASE_LAST) begin
            phase <= '0;
            acc   <= product;
            if (exp_q[idx]) begin
              op_b  <= base_q;
              state <= MULT;
            end else if (idx == '0) begin
              result    <= product;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              idx  <= idx - 1'b1;
              op_b <= product;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        MULT: begin
          if (phase == PHASE_LAST) begin
            phase <= '0;
            acc   <= product;
            if (idx == '0) begin
              result    <= product;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              idx   <= idx - 1'b1;
              op_b  <= product;
              state <= SQUARE;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_result_hold: assert property (@(posedge clk) disable iff (reset)
    out_valid && !out_ready |=> $stable(result) && out_valid);

endmodule
